// File: rtl/pulse_stretch_gen_pkg.sv
// Shared types and width helpers for the pulse stretcher and its pending counter.
package pulse_stretch_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } state_e;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretch_gen_if.sv
// Request/pulse interface of the pulse stretcher: request in, stretched pulse and status out.
interface pulse_stretch_gen_if #(
    parameter int unsigned MAX_PEND = 3
);
    import pulse_stretch_gen_pkg::*;

    localparam int unsigned PW = cnt_width(MAX_PEND);

    logic          din;
    logic          dout;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;

    modport master (output din, input dout, input busy, input pend, input ovf);
    modport slave  (input din, output dout, output busy, output pend, output ovf);

endinterface

// File: rtl/pulse_stretch_gen_sat_updown_cnt.sv
// Saturating up/down counter holding queued requests; flags an increment lost at the limit.
module sat_updown_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] count,
    output logic             drop
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             at_max;

    always_comb begin
        count_d = count_q;
        at_max  = (count_q == max);
        // A simultaneous inc and dec is a swap and can never overflow.
        drop    = inc & ~dec & at_max;
        if (inc && !dec && !at_max) begin
            count_d = count_q + WIDTH'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_stretch_gen.sv
// Turns single-cycle requests into HIGH_CYC-wide pulses separated by at least LOW_CYC low cycles.
module pulse_stretch_gen
    import pulse_stretch_gen_pkg::*;
#(
    parameter int unsigned HIGH_CYC = 2,
    parameter int unsigned LOW_CYC  = 1,
    parameter int unsigned MAX_PEND = 3
) (
    input  logic               clk,
    input  logic               resetn,
    pulse_stretch_gen_if.slave bus
);

    localparam int unsigned CW = cnt_width(max2(HIGH_CYC, LOW_CYC));
    localparam int unsigned PW = cnt_width(MAX_PEND);

    localparam logic [CW-1:0] HighLoad = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] LowLoad  = CW'(LOW_CYC - 1);
    localparam logic [PW-1:0] PendMax  = PW'(MAX_PEND);

    state_e        state_q;
    logic [CW-1:0] phase_q;
    logic          dout_q;
    logic          busy_q;
    logic          ovf_q;

    logic [PW-1:0] pend;
    logic          pend_nz;
    logic          last_phase;
    logic          inc;
    logic          dec;
    logic          drop;

    assign pend_nz    = (pend != '0);
    assign last_phase = (phase_q == '0);

    // The final LOW cycle consumes one queued request if any, else takes din directly.
    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        unique case (state_q)
            StHigh: inc = bus.din;
            StLow: begin
                if (last_phase) begin
                    dec = pend_nz;
                    inc = bus.din & pend_nz;
                end else begin
                    inc = bus.din;
                end
            end
            default: ;
        endcase
    end

    sat_updown_cnt #(
        .WIDTH (PW)
    ) u_pend_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (inc),
        .dec    (dec),
        .max    (PendMax),
        .count  (pend),
        .drop   (drop)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            phase_q <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_q | drop;
            case (state_q)
                StIdle: begin
                    if (bus.din) begin
                        state_q <= StHigh;
                        phase_q <= HighLoad;
                        dout_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StHigh: begin
                    if (last_phase) begin
                        state_q <= StLow;
                        phase_q <= LowLoad;
                        dout_q  <= 1'b0;
                    end else begin
                        phase_q <= phase_q - CW'(1);
                    end
                end
                StLow: begin
                    if (!last_phase) begin
                        phase_q <= phase_q - CW'(1);
                    end else if (pend_nz || bus.din) begin
                        state_q <= StHigh;
                        phase_q <= HighLoad;
                        dout_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    phase_q <= '0;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.pend = pend;
    assign bus.ovf  = ovf_q;

endmodule
